i2c_read_reg: RTL and testbench

I2C_READ_REG -- requirements
Module: i2c_read_reg

---
 rtl/i2c_reg_pkg.sv | 35 +++
 rtl/i2c_read_reg.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_i2c_read_reg.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_pkg.sv
// ---------------------------------------------------------------------------
// i2c_reg_pkg
// Shared definitions for the I2C register access blocks (read and write
// sides): the controller state encoding, the default watchdog timeout and
// the default retry limit, plus a helper that tells which states run under
// the external watchdog.
// ---------------------------------------------------------------------------
package i2c_reg_pkg;

    // State encodings are visible on state_out, so the numeric values are
    // fixed and must stay identical between the read and write blocks.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WAIT_BUS = 4'd1,
        CMD_WR   = 4'd2,
        SEND_REG = 4'd3,
        CMD_RD   = 4'd4,
        RECV     = 4'd5,
        STOP     = 4'd6,
        FINISH   = 4'd7,
        FAIL     = 4'd8
    } i2c_state_t;

    localparam logic [3:0] TIMER_PARAM_DEFAULT = 4'd5;
    localparam int         MAX_RETRIES_DEFAULT = 2;

    // States that wait on the bus or the core and therefore need a watchdog.
    function automatic logic isTimedState(input i2c_state_t s);
        case (s)
            WAIT_BUS, CMD_WR, SEND_REG, CMD_RD, RECV, STOP: isTimedState = 1'b1;
            default:                                        isTimedState = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_read_reg.sv
// ---------------------------------------------------------------------------
// i2c_read_reg
// Reads one register from an I2C device through an I2C master core:
// write of the register address, repeated start, single-byte read, stop.
// An external watchdog is restarted on entry to every waiting state.
//
// Optional feature: define I2C_READ_RETRY_EN to retry a missed ACK from
// WAIT_BUS up to MAX_RETRIES times before failing.
//
// Ports
//   clk, reset (async, active low)
//   dev_address[6:0], reg_address[7:0], start       request
//   data[7:0], done, message_failure                  result
//   timer_start, timer_param[3:0], timer_exp          watchdog handshake
//   i2c_cmd_*, i2c_dev_address[6:0]                   command channel
//   i2c_data_out[7:0], i2c_data_in_valid/last/ready   write-data channel
//   i2c_rx_data[7:0], i2c_rx_valid, i2c_rx_ready      read-data channel
//   i2c_bus_busy/control/active, i2c_missed_ack,
//   i2c_relinquish                                    core/arbiter status
//   i2c_control                                       bus ownership request
//   state_out[3:0]                                    current state
// ---------------------------------------------------------------------------
module i2c_read_reg
    import i2c_reg_pkg::*;
#(
    parameter logic [3:0] TIMER_PARAM = TIMER_PARAM_DEFAULT,
    parameter int         MAX_RETRIES = MAX_RETRIES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] dev_address,
    input  logic [7:0] reg_address,
    input  logic       start,
    output logic [7:0] data,
    output logic       done,
    output logic       message_failure,
    output logic       timer_start,
    output logic [3:0] timer_param,
    input  logic       timer_exp,
    output logic       i2c_cmd_valid,
    output logic       i2c_cmd_start,
    output logic       i2c_cmd_read,
    output logic       i2c_cmd_write_multiple,
    output logic       i2c_cmd_stop,
    input  logic       i2c_cmd_ready,
    output logic [6:0] i2c_dev_address,
    output logic [7:0] i2c_data_out,
    output logic       i2c_data_in_valid,
    output logic       i2c_data_in_last,
    input  logic       i2c_data_in_ready,
    input  logic [7:0] i2c_rx_data,
    input  logic       i2c_rx_valid,
    output logic       i2c_rx_ready,
    input  logic       i2c_bus_busy,
    input  logic       i2c_bus_control,
    input  logic       i2c_bus_active,
    input  logic       i2c_missed_ack,
    input  logic       i2c_relinquish,
    output logic       i2c_control,
    output logic [3:0] state_out
);

    i2c_state_t r_state;
    i2c_state_t w_nextState;

    logic [6:0] r_devAddress;
    logic [7:0] r_regAddress;
    logic [7:0] r_data;
    logic       r_timerStart;
    logic [3:0] r_timerParam;
    logic       r_abort;
    logic       r_stopSent;

    logic w_capture;
    logic w_abortReq;
    logic w_retry;
    logic w_retryOk;
    logic w_cmdValid;
    logic w_cmdStart;
    logic w_cmdRead;
    logic w_cmdWriteMultiple;
    logic w_cmdStop;
    logic w_dataInValid;
    logic w_rxReady;

`ifdef I2C_READ_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    logic [RETRY_W-1:0] r_retryCount;

    // A missed ACK may only be retried while the budget lasts; an abort in
    // progress always ends in FAIL.
    assign w_retryOk = !r_abort && (int'(r_retryCount) < MAX_RETRIES);

    // Retry counter: cleared whenever the block is idle so every new request
    // starts with the full budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retryCount <= '0;
        end else if (r_state == IDLE) begin
            r_retryCount <= '0;
        end else if (w_retry) begin
            r_retryCount <= r_retryCount + 1'b1;
        end
    end
`else
    assign w_retryOk = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and channel outputs. In the waiting states the error
    // sources are checked first: missed ACK beats everything (including a
    // simultaneous ready/valid), then arbiter relinquish, then the watchdog.
    // A relinquish while the core still holds the bus diverts to STOP with
    // the abort flag set so a stop command goes out before FAIL.
    always_comb begin
        w_nextState        = r_state;
        w_capture          = 1'b0;
        w_abortReq         = 1'b0;
        w_retry            = 1'b0;
        w_cmdValid         = 1'b0;
        w_cmdStart         = 1'b0;
        w_cmdRead          = 1'b0;
        w_cmdWriteMultiple = 1'b0;
        w_cmdStop          = 1'b0;
        w_dataInValid      = 1'b0;
        w_rxReady          = 1'b0;

        case (r_state)
            CMD_WR: begin
                w_cmdValid         = 1'b1;
                w_cmdStart         = 1'b1;
                w_cmdWriteMultiple = 1'b1;
            end
            SEND_REG: begin
                w_dataInValid = 1'b1;
            end
            CMD_RD: begin
                w_cmdValid = 1'b1;
                w_cmdStart = 1'b1;
                w_cmdRead  = 1'b1;
                w_cmdStop  = 1'b1;
            end
            RECV: begin
                w_rxReady = 1'b1;
            end
            STOP: begin
                w_cmdValid = r_abort && !r_stopSent;
                w_cmdStop  = r_abort && !r_stopSent;
            end
            default: begin
            end
        endcase

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = WAIT_BUS;
                end
            end
            FINISH, FAIL: begin
                w_nextState = IDLE;
            end
            WAIT_BUS, CMD_WR, SEND_REG, CMD_RD, RECV, STOP: begin
                if (i2c_missed_ack) begin
                    if (w_retryOk) begin
                        w_nextState = WAIT_BUS;
                        w_retry     = 1'b1;
                    end else begin
                        w_nextState = FAIL;
                    end
                end else if (i2c_relinquish && !r_abort) begin
                    if (i2c_bus_control) begin
                        w_nextState = STOP;
                        w_abortReq  = 1'b1;
                    end else begin
                        w_nextState = FAIL;
                    end
                end else if (timer_exp) begin
                    w_nextState = FAIL;
                end else begin
                    case (r_state)
                        WAIT_BUS: if (!i2c_bus_active && !i2c_bus_busy) w_nextState = CMD_WR;
                        CMD_WR:   if (i2c_cmd_ready)                     w_nextState = SEND_REG;
                        SEND_REG: if (i2c_data_in_ready)                 w_nextState = CMD_RD;
                        CMD_RD:   if (i2c_cmd_ready)                     w_nextState = RECV;
                        RECV: begin
                            if (i2c_rx_valid) begin
                                w_nextState = STOP;
                                w_capture   = 1'b1;
                            end
                        end
                        STOP: begin
                            if (!(r_abort && !r_stopSent) && !i2c_bus_busy) begin
                                w_nextState = r_abort ? FAIL : FINISH;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request latch, result byte and watchdog kick. The result is cleared on
    // entry to FAIL so a failed read never presents stale data. timer_start
    // is registered so it is a clean one-cycle pulse in the first cycle of
    // each waiting state, including a WAIT_BUS re-entry on retry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_devAddress <= '0;
            r_regAddress <= '0;
            r_data       <= '0;
            r_timerStart <= 1'b0;
            r_timerParam <= '0;
        end else begin
            r_timerParam <= TIMER_PARAM;
            r_timerStart <= ((w_nextState != r_state) || w_retry) && isTimedState(w_nextState);
            if (r_state == IDLE && start) begin
                r_devAddress <= dev_address;
                r_regAddress <= reg_address;
            end
            if (w_nextState == FAIL) begin
                r_data <= '0;
            end else if (w_capture) begin
                r_data <= i2c_rx_data;
            end
        end
    end

    // Abort bookkeeping for the relinquish path: r_abort marks that the
    // transaction must end in FAIL, r_stopSent that the stop command has
    // been accepted by the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_abort    <= 1'b0;
            r_stopSent <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_abort <= 1'b0;
            end else if (w_abortReq) begin
                r_abort <= 1'b1;
            end
            if (r_state != STOP) begin
                r_stopSent <= 1'b0;
            end else if (r_abort && w_cmdValid && i2c_cmd_ready) begin
                r_stopSent <= 1'b1;
            end
        end
    end

    assign state_out              = r_state;
    assign data                   = r_data;
    assign done                   = (r_state == FINISH) || (r_state == FAIL);
    assign message_failure        = (r_state == FAIL);
    assign timer_start            = r_timerStart;
    assign timer_param            = r_timerParam;
    assign i2c_cmd_valid          = w_cmdValid;
    assign i2c_cmd_start          = w_cmdStart;
    assign i2c_cmd_read           = w_cmdRead;
    assign i2c_cmd_write_multiple = w_cmdWriteMultiple;
    assign i2c_cmd_stop           = w_cmdStop;
    assign i2c_dev_address        = r_devAddress;
    assign i2c_data_out           = w_dataInValid ? r_regAddress : 8'h00;
    assign i2c_data_in_valid      = w_dataInValid;
    assign i2c_data_in_last       = w_dataInValid;
    assign i2c_rx_ready           = w_rxReady;
    assign i2c_control            = (r_state != IDLE) && (r_state != FINISH) && (r_state != FAIL);

endmodule

// File: tb/tb_i2c_read_reg.sv
// ---------------------------------------------------------------------------
// tb_i2c_read_reg
// Self-checking bench for i2c_read_reg: a table of zero-wait read
// transactions plus hand-written sequences for missed ACK, watchdog expiry,
// relinquish, reset mid-transaction and start while busy.
// ---------------------------------------------------------------------------
module tb_i2c_read_reg;

    logic       clk;
    logic       reset;
    logic [6:0] devAddress;
    logic [7:0] regAddress;
    logic       start;
    logic [7:0] data;
    logic       done;
    logic       messageFailure;
    logic       timerStart;
    logic [3:0] timerParam;
    logic       timerExp;
    logic       cmdValid;
    logic       cmdStart;
    logic       cmdRead;
    logic       cmdWriteMultiple;
    logic       cmdStop;
    logic       cmdReady;
    logic [6:0] i2cDevAddress;
    logic [7:0] dataOut;
    logic       dataInValid;
    logic       dataInLast;
    logic       dataInReady;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic       busBusy;
    logic       busControl;
    logic       busActive;
    logic       missedAck;
    logic       relinquish;
    logic       i2cControl;
    logic [3:0] stateOut;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] dev;
        logic [7:0] regAddr;
        logic [7:0] rx;
        logic [7:0] expData;
        logic       expFail;
        int         expLatency;
    } vector_t;

    vector_t vectors[4];

    logic [63:0] allOut;
    assign allOut = {21'd0, data, done, messageFailure, timerStart, timerParam,
                     cmdValid, cmdStart, cmdRead, cmdWriteMultiple, cmdStop,
                     i2cDevAddress, dataOut, dataInValid, dataInLast, rxReady,
                     i2cControl, stateOut};

    i2c_read_reg dut (
        .clk                    (clk),
        .reset                  (reset),
        .dev_address            (devAddress),
        .reg_address            (regAddress),
        .start                  (start),
        .data                   (data),
        .done                   (done),
        .message_failure        (messageFailure),
        .timer_start            (timerStart),
        .timer_param            (timerParam),
        .timer_exp              (timerExp),
        .i2c_cmd_valid          (cmdValid),
        .i2c_cmd_start          (cmdStart),
        .i2c_cmd_read           (cmdRead),
        .i2c_cmd_write_multiple (cmdWriteMultiple),
        .i2c_cmd_stop           (cmdStop),
        .i2c_cmd_ready          (cmdReady),
        .i2c_dev_address        (i2cDevAddress),
        .i2c_data_out           (dataOut),
        .i2c_data_in_valid      (dataInValid),
        .i2c_data_in_last       (dataInLast),
        .i2c_data_in_ready      (dataInReady),
        .i2c_rx_data            (rxData),
        .i2c_rx_valid           (rxValid),
        .i2c_rx_ready           (rxReady),
        .i2c_bus_busy           (busBusy),
        .i2c_bus_control        (busControl),
        .i2c_bus_active         (busActive),
        .i2c_missed_ack         (missedAck),
        .i2c_relinquish         (relinquish),
        .i2c_control            (i2cControl),
        .state_out              (stateOut)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and reports it when it does not hold.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Wait, within a cycle budget, for a given state; arriving is a check.
    task automatic waitState(input logic [3:0] s, input int budget);
        int n = 0;
        while (stateOut !== s && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput($sformatf("reach_state_%0d", s), {60'd0, stateOut}, {60'd0, s});
    endtask

    // Issue a one-cycle start request from IDLE.
    task automatic startTxn(input logic [6:0] dev, input logic [7:0] regA);
        devAddress = dev;
        regAddress = regA;
        start      = 1'b1;
        stepCycle();
        start      = 1'b0;
        devAddress = ~dev;
        regAddress = ~regA;
    endtask

    // Run one zero-wait transaction from a table record and check latency,
    // the visible state sequence, the addresses presented to the core, the
    // watchdog kicks and the result.
    task automatic applyStimulus(input vector_t v, input int idx);
        int         latency;
        int         kicks;
        logic       seqOk;
        logic       paramOk;
        logic [6:0] seenDev;
        logic [7:0] seenReg;
        rxData  = v.rx;
        startTxn(v.dev, v.regAddr);
        latency = 1;
        kicks   = 0;
        seqOk   = 1'b1;
        paramOk = 1'b1;
        seenDev = '0;
        seenReg = '0;
        while (!done && latency < 40) begin
            if (stateOut !== latency[3:0]) seqOk = 1'b0;
            if (timerStart) begin
                kicks++;
                if (timerParam !== 4'd5) paramOk = 1'b0;
            end
            if (stateOut == 4'd2) seenDev = i2cDevAddress;
            if (stateOut == 4'd3 && dataInValid && dataInLast) seenReg = dataOut;
            stepCycle();
            latency++;
        end
        checkOutput($sformatf("v%0d_latency", idx), latency, v.expLatency);
        checkOutput($sformatf("v%0d_data", idx), {56'd0, data}, {56'd0, v.expData});
        checkOutput($sformatf("v%0d_failure", idx), {63'd0, messageFailure}, {63'd0, v.expFail});
        checkOutput($sformatf("v%0d_state_seq", idx), {63'd0, seqOk}, 64'd1);
        checkOutput($sformatf("v%0d_dev_addr", idx), {57'd0, seenDev}, {57'd0, v.dev});
        checkOutput($sformatf("v%0d_reg_addr", idx), {56'd0, seenReg}, {56'd0, v.regAddr});
        checkOutput($sformatf("v%0d_timer_kicks", idx), kicks, 6);
        checkOutput($sformatf("v%0d_timer_param", idx), {63'd0, paramOk}, 64'd1);
        stepCycle();
        checkOutput($sformatf("v%0d_back_idle", idx), {59'd0, done, stateOut}, 64'd0);
    endtask

    initial begin
        int doneCount;

        vectors[0] = '{dev: 7'h29, regAddr: 8'h69, rx: 8'h73, expData: 8'h73, expFail: 1'b0, expLatency: 7};
        vectors[1] = '{dev: 7'h50, regAddr: 8'h00, rx: 8'hFF, expData: 8'hFF, expFail: 1'b0, expLatency: 7};
        vectors[2] = '{dev: 7'h7F, regAddr: 8'hFF, rx: 8'h00, expData: 8'h00, expFail: 1'b0, expLatency: 7};
        vectors[3] = '{dev: 7'h01, regAddr: 8'h80, rx: 8'h5A, expData: 8'h5A, expFail: 1'b0, expLatency: 7};

        reset       = 1'b1;
        devAddress  = 7'h29;
        regAddress  = 8'h69;
        start       = 1'b1;
        timerExp    = 1'b0;
        cmdReady    = 1'b1;
        dataInReady = 1'b1;
        rxData      = 8'h73;
        rxValid     = 1'b1;
        busBusy     = 1'b0;
        busControl  = 1'b1;
        busActive   = 1'b0;
        missedAck   = 1'b0;
        relinquish  = 1'b0;

        // Reset held with a start request pending: everything stays at zero.
        #2 reset = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset_outputs_zero", allOut, 64'd0);
        start = 1'b0;
        reset = 1'b1;
        stepCycle();
        checkOutput("post_reset_idle", {60'd0, stateOut}, 64'd0);
        checkOutput("post_reset_timer_param", {60'd0, timerParam}, 64'd5);

        // Table of nominal zero-wait reads.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i], i);
        end

        // Missed ACK during SEND_REG, with data_in_ready high at the same time.
        startTxn(7'h29, 8'h69);
`ifdef I2C_READ_RETRY_EN
        for (int a = 0; a < 2; a++) begin
            waitState(4'd3, 20);
            missedAck = 1'b1;
            stepCycle();
            missedAck = 1'b0;
            checkOutput($sformatf("retry%0d_state", a), {60'd0, stateOut}, 64'd1);
            checkOutput($sformatf("retry%0d_timer_start", a), {63'd0, timerStart}, 64'd1);
        end
`endif
        waitState(4'd3, 20);
        missedAck = 1'b1;
        stepCycle();
        missedAck = 1'b0;
        checkOutput("nack_state", {60'd0, stateOut}, 64'd8);
        checkOutput("nack_done", {63'd0, done}, 64'd1);
        checkOutput("nack_failure", {63'd0, messageFailure}, 64'd1);
        checkOutput("nack_data", {56'd0, data}, 64'd0);
        checkOutput("nack_control", {63'd0, i2cControl}, 64'd0);
        stepCycle();
        checkOutput("nack_back_idle", {59'd0, done, stateOut}, 64'd0);

        // Command never accepted in CMD_RD, then the watchdog fires.
        startTxn(7'h12, 8'h34);
        waitState(4'd4, 20);
        cmdReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput($sformatf("cmdrd_hold%0d", c), {58'd0, stateOut, cmdValid, cmdRead},
                        {58'd0, 4'd4, 1'b1, 1'b1});
        end
        timerExp = 1'b1;
        stepCycle();
        timerExp = 1'b0;
        checkOutput("timeout_state", {60'd0, stateOut}, 64'd8);
        checkOutput("timeout_done_fail", {62'd0, done, messageFailure}, 64'd3);
        checkOutput("timeout_valid_dropped", {63'd0, cmdValid}, 64'd0);
        cmdReady = 1'b1;
        stepCycle();

        // Arbiter relinquish while the core holds the bus: stop, then FAIL.
        startTxn(7'h12, 8'h34);
        waitState(4'd4, 20);
        cmdReady   = 1'b0;
        relinquish = 1'b1;
        stepCycle();
        relinquish = 1'b0;
        checkOutput("relinq_stop_state", {60'd0, stateOut}, 64'd6);
        checkOutput("relinq_stop_cmd", {59'd0, cmdValid, cmdStart, cmdRead, cmdWriteMultiple, cmdStop},
                    {59'd0, 5'b10001});
        cmdReady = 1'b1;
        stepCycle();
        checkOutput("relinq_stop_accepted", {59'd0, cmdValid, stateOut}, {59'd0, 1'b0, 4'd6});
        stepCycle();
        checkOutput("relinq_fail", {58'd0, done, messageFailure, stateOut}, {58'd0, 2'b11, 4'd8});
        stepCycle();

        // Reset asserted in RECV, then a fresh read must start from scratch.
        rxValid = 1'b0;
        startTxn(7'h29, 8'h69);
        waitState(4'd5, 20);
        checkOutput("recv_rx_ready", {63'd0, rxReady}, 64'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("reset_recv_outputs_zero", allOut, 64'd0);
        stepCycle();
        reset   = 1'b1;
        rxValid = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("reset_no_resume", {59'd0, done, stateOut}, 64'd0);
        applyStimulus('{dev: 7'h29, regAddr: 8'h10, rx: 8'hA5, expData: 8'hA5, expFail: 1'b0, expLatency: 7}, 4);

        // Start pulsed while in RECV is ignored; only one done results.
        rxValid = 1'b0;
        rxData  = 8'h3C;
        startTxn(7'h29, 8'h69);
        waitState(4'd5, 20);
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        checkOutput("busy_start_state", {60'd0, stateOut}, 64'd5);
        stepCycle();
        checkOutput("busy_start_still_recv", {60'd0, stateOut}, 64'd5);
        rxValid   = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            if (done) doneCount++;
        end
        checkOutput("busy_start_one_done", doneCount, 1);
        checkOutput("busy_start_data", {56'd0, data}, 64'h3C);
        checkOutput("busy_start_idle", {60'd0, stateOut}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
